// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction prefetch stage in front of the CPU fetch/decode input.
// Owns the fetch PC, issues reads to a 1-cycle-latency instruction memory,
// queues returned {addr, data} pairs in a small FIFO and presents the head
// instruction to the CPU. A taken-branch redirect flushes the queue and drops
// every read still in flight.
module fetch_buffer #(
    parameter int unsigned       ADDR_W     = 11,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       DEPTH      = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter logic [DATA_W-1:0] NOOP_WORD  = '0
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_addr,
    input  logic                       instr_ready,
    output logic                       imem_rd_en,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [DATA_W-1:0]          imem_rdata,
    output logic [DATA_W-1:0]          instr_out,
    output logic                       instr_valid,
    output logic [ADDR_W-1:0]          instr_pc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Fetch side
    logic [ADDR_W-1:0] fetch_pc_q,  fetch_pc_d;
    logic              rd_en_q,     rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q,   rd_addr_d;

    // Read whose data is on imem_rdata this cycle, and the address it was issued for
    logic              pend_q,      pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;

    // FIFO bookkeeping
    logic [PTR_W-1:0]  wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,    rd_ptr_d;
    logic [CNT_W-1:0]  count_q,     count_d;

    // FIFO storage
    logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
    logic [DATA_W-1:0] fifo_data_q [DEPTH];

    logic              push;
    logic              pop;
    logic              issue;
    logic [CNT_W:0]    credit;

    // Handshake decode: redirect overrides both the return push and the CPU pop
    always_comb begin
        push   = pend_q && !redirect_valid;
        pop    = instr_ready && (count_q != '0) && !redirect_valid;
        // Two reads can be outstanding (one just issued, one returning), so both
        // are charged against free space; a pop this cycle earns no credit.
        credit = {1'b0, count_q}
               + {{CNT_W{1'b0}}, rd_en_q}
               + {{CNT_W{1'b0}}, pend_q};
        issue  = !redirect_valid && (credit < (CNT_W+1)'(DEPTH));
    end

    // Next-state computation for fetch, in-flight tracking and FIFO pointers
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        pend_d      = rd_en_q;
        pend_addr_d = rd_addr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        if (redirect_valid) begin
            // Restart at the branch target immediately; the read issued this
            // cycle is stale, so it must not be tracked as returning.
            rd_en_d    = 1'b1;
            rd_addr_d  = redirect_addr;
            fetch_pc_d = redirect_addr + ADDR_W'(1);
            pend_d     = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                rd_en_d    = 1'b1;
                rd_addr_d  = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + ADDR_W'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            fetch_pc_q  <= RESET_ADDR;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage write; returning data is never captured during reset
    always_ff @(posedge clk) begin
        if (resetn && push) begin
            fifo_addr_q[wr_ptr_q] <= pend_addr_q;
            fifo_data_q[wr_ptr_q] <= imem_rdata;
        end
    end

    // Outputs driven straight from registered state and the FIFO head
    always_comb begin
        imem_rd_en  = rd_en_q;
        imem_addr   = rd_addr_q;
        count       = count_q;
        instr_valid = (count_q != '0);
        instr_out   = NOOP_WORD;
        instr_pc    = '0;
        if (count_q != '0) begin
            instr_out = fifo_data_q[rd_ptr_q];
            instr_pc  = fifo_addr_q[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed self-checking bench for fetch_buffer.
// A behavioural 1-cycle-latency memory returns 0xA500_0000 | addr, so every
// word identifies its own address and an idle bus returns 0xDEAD_BEEF.
module tb_fetch_buffer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        redirect_valid;
    logic [10:0] redirect_addr;
    logic        instr_ready;
    logic        imem_rd_en;
    logic [10:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [10:0] instr_pc;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    fetch_buffer #(
        .ADDR_W     (11),
        .DATA_W     (32),
        .DEPTH      (4),
        .RESET_ADDR (11'h000),
        .NOOP_WORD  (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .instr_ready    (instr_ready),
        .imem_rd_en     (imem_rd_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .instr_out      (instr_out),
        .instr_valid    (instr_valid),
        .instr_pc       (instr_pc),
        .count          (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [10:0] a);
        return 32'hA500_0000 | {21'b0, a};
    endfunction

    // Instruction memory model: data valid one cycle after the read enable
    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= word_of(imem_addr);
        else            imem_rdata <= 32'hDEAD_BEEF;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0: first cycle with resetn=1
    task automatic do_reset;
        resetn = 1'b0; redirect_valid = 1'b0; redirect_addr = '0; instr_ready = 1'b0;
        tick; tick;
        resetn = 1'b1;
    endtask

    task automatic test_reset;
        resetn = 1'b0; redirect_valid = 1'b0; redirect_addr = '0; instr_ready = 1'b1;
        tick; tick;
        checks++;
        if ({instr_valid, instr_pc, instr_out} !== {1'b0, 11'h000, 32'h0}) begin
            errors++;
            $display("FAIL reset_outputs: got v=%0b pc=%h out=%h, want v=0 pc=000 out=00000000",
                     instr_valid, instr_pc, instr_out);
        end
        checks++;
        if ({imem_rd_en, count} !== {1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset_state: got rd_en=%0b count=%0d, want rd_en=0 count=0", imem_rd_en, count);
        end
    endtask

    task automatic test_startup;
        do_reset;
        instr_ready = 1'b1;
        checks++;
        if (imem_rd_en !== 1'b0) begin
            errors++; $display("FAIL start_c0_rd_en: got %0b want 0", imem_rd_en);
        end
        tick;
        checks++;
        if ({imem_rd_en, imem_addr, instr_valid} !== {1'b1, 11'h000, 1'b0}) begin
            errors++;
            $display("FAIL start_c1: got rd_en=%0b addr=%h v=%0b, want 1 000 0", imem_rd_en, imem_addr, instr_valid);
        end
        tick;
        checks++;
        if ({imem_rd_en, imem_addr, instr_valid} !== {1'b1, 11'h001, 1'b0}) begin
            errors++;
            $display("FAIL start_c2: got rd_en=%0b addr=%h v=%0b, want 1 001 0", imem_rd_en, imem_addr, instr_valid);
        end
        tick;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({instr_valid, instr_pc, instr_out} !== {1'b1, 11'(i), word_of(11'(i))}) begin
                errors++;
                $display("FAIL stream_head[%0d]: got v=%0b pc=%h out=%h, want v=1 pc=%h out=%h",
                         i, instr_valid, instr_pc, instr_out, 11'(i), word_of(11'(i)));
            end
            checks++;
            if ({count, imem_rd_en, imem_addr} !== {3'd1, 1'b1, 11'(i + 2)}) begin
                errors++;
                $display("FAIL stream_fetch[%0d]: got count=%0d rd_en=%0b addr=%h, want 1 1 %h",
                         i, count, imem_rd_en, imem_addr, 11'(i + 2));
            end
            tick;
        end
    endtask

    task automatic test_stall;
        do_reset;
        instr_ready = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick;
            checks++;
            if (count !== 3'((c < 3) ? 0 : (c < 6) ? c - 2 : 4)) begin
                errors++;
                $display("FAIL stall_count[c%0d]: got %0d want %0d", c, count, (c < 3) ? 0 : (c < 6) ? c - 2 : 4);
            end
            checks++;
            if (imem_rd_en !== ((c <= 4) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL stall_rd_en[c%0d]: got %0b want %0b", c, imem_rd_en, (c <= 4));
            end
        end
        instr_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if ({instr_valid, instr_pc, instr_out} !== {1'b1, 11'(i), word_of(11'(i))}) begin
                errors++;
                $display("FAIL release_head[%0d]: got v=%0b pc=%h out=%h, want v=1 pc=%h out=%h",
                         i, instr_valid, instr_pc, instr_out, 11'(i), word_of(11'(i)));
            end
            if (i == 1) begin
                checks++;
                if (imem_rd_en !== 1'b0) begin
                    errors++; $display("FAIL release_no_issue: got rd_en=%0b want 0", imem_rd_en);
                end
            end
            if (i == 2) begin
                checks++;
                if ({imem_rd_en, imem_addr} !== {1'b1, 11'h004}) begin
                    errors++;
                    $display("FAIL release_resume: got rd_en=%0b addr=%h want 1 004", imem_rd_en, imem_addr);
                end
            end
            tick;
        end
    endtask

    task automatic test_redirect_flush;
        do_reset;
        instr_ready = 1'b0;
        repeat (5) tick;
        checks++;
        if (count !== 3'd3) begin
            errors++; $display("FAIL flush_pre_count: got %0d want 3", count);
        end
        redirect_valid = 1'b1; redirect_addr = 11'h100;
        tick;
        redirect_valid = 1'b0; instr_ready = 1'b1;
        checks++;
        if ({count, instr_valid, instr_pc, instr_out} !== {3'd0, 1'b0, 11'h000, 32'h0}) begin
            errors++;
            $display("FAIL flush_cleared: got count=%0d v=%0b pc=%h out=%h, want 0 0 000 00000000",
                     count, instr_valid, instr_pc, instr_out);
        end
        checks++;
        if ({imem_rd_en, imem_addr} !== {1'b1, 11'h100}) begin
            errors++; $display("FAIL flush_fetch: got rd_en=%0b addr=%h want 1 100", imem_rd_en, imem_addr);
        end
        tick;
        checks++;
        if ({instr_valid, count} !== {1'b0, 3'd0}) begin
            errors++; $display("FAIL flush_stale: got v=%0b count=%0d want 0 0", instr_valid, count);
        end
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if ({instr_valid, instr_pc, instr_out} !== {1'b1, 11'(11'h100 + i), word_of(11'(11'h100 + i))}) begin
                errors++;
                $display("FAIL flush_target[%0d]: got v=%0b pc=%h out=%h, want v=1 pc=%h",
                         i, instr_valid, instr_pc, instr_out, 11'(11'h100 + i));
            end
        end
    endtask

    task automatic test_redirect_pop_and_wrap;
        do_reset;
        instr_ready = 1'b1;
        repeat (4) tick;
        checks++;
        if ({count, instr_valid} !== {3'd1, 1'b1}) begin
            errors++; $display("FAIL pop_pre: got count=%0d v=%0b want 1 1", count, instr_valid);
        end
        redirect_valid = 1'b1; redirect_addr = 11'h040;
        tick;
        redirect_valid = 1'b0;
        checks++;
        if ({count, instr_valid} !== {3'd0, 1'b0}) begin
            errors++; $display("FAIL pop_redirect_count: got count=%0d v=%0b want 0 0", count, instr_valid);
        end
        tick; tick;
        checks++;
        if ({instr_valid, instr_pc} !== {1'b1, 11'h040}) begin
            errors++; $display("FAIL pop_target: got v=%0b pc=%h want 1 040", instr_valid, instr_pc);
        end
        tick;
        checks++;
        if ({instr_valid, instr_pc} !== {1'b1, 11'h041}) begin
            errors++; $display("FAIL pop_target_next: got v=%0b pc=%h want 1 041", instr_valid, instr_pc);
        end
        redirect_valid = 1'b1; redirect_addr = 11'h7FE;
        tick;
        redirect_valid = 1'b0;
        checks++;
        if ({imem_rd_en, imem_addr} !== {1'b1, 11'h7FE}) begin
            errors++; $display("FAIL wrap_fetch0: got rd_en=%0b addr=%h want 1 7fe", imem_rd_en, imem_addr);
        end
        tick;
        checks++;
        if (imem_addr !== 11'h7FF) begin
            errors++; $display("FAIL wrap_fetch1: got addr=%h want 7ff", imem_addr);
        end
        tick;
        checks++;
        if (imem_addr !== 11'h000) begin
            errors++; $display("FAIL wrap_fetch2: got addr=%h want 000", imem_addr);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({instr_valid, instr_pc, instr_out} !== {1'b1, 11'(11'h7FE + i), word_of(11'(11'h7FE + i))}) begin
                errors++;
                $display("FAIL wrap_head[%0d]: got v=%0b pc=%h out=%h, want v=1 pc=%h",
                         i, instr_valid, instr_pc, instr_out, 11'(11'h7FE + i));
            end
            tick;
        end
    endtask

    task automatic test_back_to_back;
        redirect_valid = 1'b1; redirect_addr = 11'h200; instr_ready = 1'b1;
        tick;
        redirect_addr = 11'h300;
        checks++;
        if ({imem_rd_en, imem_addr, count} !== {1'b1, 11'h200, 3'd0}) begin
            errors++;
            $display("FAIL b2b_first: got rd_en=%0b addr=%h count=%0d want 1 200 0", imem_rd_en, imem_addr, count);
        end
        tick;
        redirect_valid = 1'b0;
        checks++;
        if ({imem_rd_en, imem_addr, count} !== {1'b1, 11'h300, 3'd0}) begin
            errors++;
            $display("FAIL b2b_last: got rd_en=%0b addr=%h count=%0d want 1 300 0", imem_rd_en, imem_addr, count);
        end
        tick;
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_stale: got v=%0b pc=%h want v=0", instr_valid, instr_pc);
        end
        tick;
        checks++;
        if ({instr_valid, instr_pc, instr_out} !== {1'b1, 11'h300, word_of(11'h300)}) begin
            errors++;
            $display("FAIL b2b_target: got v=%0b pc=%h out=%h want 1 300 %h", instr_valid, instr_pc, instr_out, word_of(11'h300));
        end
        tick;
        checks++;
        if ({instr_valid, instr_pc} !== {1'b1, 11'h301}) begin
            errors++; $display("FAIL b2b_next: got v=%0b pc=%h want 1 301", instr_valid, instr_pc);
        end
    endtask

    task automatic test_mid_reset;
        do_reset;
        instr_ready = 1'b0;
        repeat (4) tick;
        checks++;
        if ({count, imem_rd_en} !== {3'd2, 1'b1}) begin
            errors++; $display("FAIL midrst_pre: got count=%0d rd_en=%0b want 2 1", count, imem_rd_en);
        end
        resetn = 1'b0;
        tick;
        resetn = 1'b1; instr_ready = 1'b1;
        checks++;
        if ({count, imem_rd_en, instr_valid, instr_pc, instr_out} !== {3'd0, 1'b0, 1'b0, 11'h000, 32'h0}) begin
            errors++;
            $display("FAIL midrst_values: got count=%0d rd_en=%0b v=%0b pc=%h out=%h, want 0 0 0 000 00000000",
                     count, imem_rd_en, instr_valid, instr_pc, instr_out);
        end
        tick;
        checks++;
        if ({imem_rd_en, imem_addr, count} !== {1'b1, 11'h000, 3'd0}) begin
            errors++;
            $display("FAIL midrst_refetch: got rd_en=%0b addr=%h count=%0d want 1 000 0", imem_rd_en, imem_addr, count);
        end
        tick;
        checks++;
        if ({instr_valid, count} !== {1'b0, 3'd0}) begin
            errors++; $display("FAIL midrst_stale: got v=%0b count=%0d pc=%h want v=0 count=0", instr_valid, count, instr_pc);
        end
        tick;
        checks++;
        if ({instr_valid, instr_pc, instr_out} !== {1'b1, 11'h000, word_of(11'h000)}) begin
            errors++;
            $display("FAIL midrst_first: got v=%0b pc=%h out=%h want 1 000 %h", instr_valid, instr_pc, instr_out, word_of(11'h000));
        end
    endtask

    initial begin
        test_reset;
        test_startup;
        test_stall;
        test_redirect_flush;
        test_redirect_pop_and_wrap;
        test_back_to_back;
        test_mid_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
